// File: rtl/subbytes_scheduler_pkg.sv
// Shared types, constants and GF(2^8) helpers for the time-multiplexed SubBytes engine.
// The S-box is computed as the multiplicative inverse followed by the AES affine map.
package subbytes_scheduler_pkg;

   localparam int WORDS  = 4;
   localparam int WORD_W = 32;

   localparam bit ARB_RR        = 1'b0;
   localparam bit ARB_KEY_FIRST = 1'b1;

   typedef enum logic [1:0] {IDLE, ST_BUSY, KW_BUSY} state_t;
   typedef enum logic {WIN_STATE, WIN_KEY} win_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      logic [7:0] x3, x7, x15, x31, x63, x127, inv;
      // x^254 is the inverse in GF(2^8), and maps 0 to 0 as the S-box requires
      x3   = gf_mul(gf_mul(x, x), x);
      x7   = gf_mul(gf_mul(x3, x3), x);
      x15  = gf_mul(gf_mul(x7, x7), x);
      x31  = gf_mul(gf_mul(x15, x15), x);
      x63  = gf_mul(gf_mul(x31, x31), x);
      x127 = gf_mul(gf_mul(x63, x63), x);
      inv  = gf_mul(x127, x127);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/subbytes_scheduler_sub_word.sv
// Purely combinational 32-bit SubWord built from four byte S-boxes.
// Shared between the round datapath and the key expansion.
module S_Box
   import subbytes_scheduler_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);
   assign y = sbox_byte(a);
endmodule

module sub_word
   import subbytes_scheduler_pkg::*;
(
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout
);
   for (genvar i = 0; i < 4; i++) begin : g_sbox
      S_Box u_sbox (
         .a (din[8*i +: 8]),
         .y (dout[8*i +: 8])
      );
   end
endmodule

// File: rtl/subbytes_scheduler.sv
// Arbitrates the round state and the key schedule onto one shared SubWord bank,
// streaming the 128-bit state through it one word per cycle.
module subbytes_scheduler
   import subbytes_scheduler_pkg::*;
#(
   parameter bit ARB_MODE = ARB_RR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req,
   input  logic [127:0] st_data,
   output logic         st_gnt,
   output logic         st_valid,
   output logic [127:0] st_out,
   input  logic         kw_req,
   input  logic [31:0]  kw_data,
   output logic         kw_gnt,
   output logic         kw_valid,
   output logic [31:0]  kw_out
);

   state_t              state, state_nxt;
   logic [1:0]          cnt;
   win_t                last_win;
   logic [127:0]        st_buf;
   logic [WORD_W-1:0]   kw_buf;
   logic [WORD_W-1:0]   bank_in;
   logic [WORD_W-1:0]   bank_out;
   logic                last_word;

   assign last_word = (cnt == 2'(WORDS - 1));

   always_comb begin
      st_gnt    = 1'b0;
      kw_gnt    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rst) begin
               if (st_req && kw_req) begin
                  if (ARB_MODE == ARB_KEY_FIRST || last_win == WIN_STATE) kw_gnt = 1'b1;
                  else                                                   st_gnt = 1'b1;
               end else if (st_req) begin
                  st_gnt = 1'b1;
               end else if (kw_req) begin
                  kw_gnt = 1'b1;
               end
            end
            if (st_gnt)      state_nxt = ST_BUSY;
            else if (kw_gnt) state_nxt = KW_BUSY;
         end
         ST_BUSY: if (last_word) state_nxt = IDLE;
         KW_BUSY: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // word 0 of the state is the most significant word
   always_comb begin
      bank_in = kw_buf;
      if (state == ST_BUSY) begin
         case (cnt)
            2'd0:    bank_in = st_buf[127:96];
            2'd1:    bank_in = st_buf[95:64];
            2'd2:    bank_in = st_buf[63:32];
            default: bank_in = st_buf[31:0];
         endcase
      end
   end

   sub_word u_sub_word (
      .din  (bank_in),
      .dout (bank_out)
   );

   always_ff @(posedge clk) begin
      if (st_gnt) st_buf <= st_data;
      if (kw_gnt) kw_buf <= kw_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         last_win <= WIN_STATE;
         st_valid <= 1'b0;
         kw_valid <= 1'b0;
         st_out   <= '0;
         kw_out   <= '0;
      end else begin
         state    <= state_nxt;
         st_valid <= (state == ST_BUSY) && last_word;
         kw_valid <= (state == KW_BUSY);
         if (st_gnt) begin
            cnt      <= 2'd0;
            last_win <= WIN_STATE;
         end
         if (kw_gnt) last_win <= WIN_KEY;
         if (state == ST_BUSY) begin
            cnt <= cnt + 2'd1;
            case (cnt)
               2'd0:    st_out[127:96] <= bank_out;
               2'd1:    st_out[95:64]  <= bank_out;
               2'd2:    st_out[63:32]  <= bank_out;
               default: st_out[31:0]   <= bank_out;
            endcase
         end
         if (state == KW_BUSY) kw_out <= bank_out;
      end
   end

endmodule
